// File: rtl/bus_fabric_pkg.sv
// Shared types and decode constants for bus_fabric_param.
// BUS_ADDR / BUS_DATA normally come from bus.h; 32-bit defaults apply when it is not included.
`ifndef BUS_ADDR
`define BUS_ADDR 32
`endif
`ifndef BUS_DATA
`define BUS_DATA 32
`endif

package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } bus_fsm_e;

  localparam int ADDR_W   = `BUS_ADDR;
  localparam int DATA_W   = `BUS_DATA;
  localparam int ADDR_MSB = ADDR_W - 1;

  localparam logic [DATA_W-1:0] ERR_RDATA = '0;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: search starts one past last_owner and wraps to 0.
module bus_rr_arbiter #(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] last_owner,
  input  logic                         en,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] idx
);

  localparam int IW = $clog2(N_MASTERS);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = 0;
    found = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = int'(last_owner) + i;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      if (en && !found && req[IW'(cand)]) begin
        found             = 1'b1;
        gnt[IW'(cand)]    = 1'b1;
        idx               = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_fabric_param.sv
// Shared-bus fabric: N masters, M slaves, round-robin grant held per transaction.
// Define BUS_TIMEOUT_EN to add the slave-ready timeout error response.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// GRANT | owner granted, waiting for its address strobe
// BUSY  | transaction issued; routing response from the latched slave
module bus_fabric_param
  import bus_fabric_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int N_SLAVES       = 5,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTERS-1:0]                 req_m,
  input  logic [N_MASTERS-1:0][`BUS_ADDR-1:0]  addr_m,
  input  logic [N_MASTERS-1:0][`BUS_DATA-1:0]  wr_data_m,
  input  logic [N_MASTERS-1:0]                 we_m,
  input  logic [N_MASTERS-1:0][3:0]            sel_m,
  input  logic [N_MASTERS-1:0]                 addr_strobe_m,
  output logic [N_MASTERS-1:0]                 grant_m,
  output logic [`BUS_ADDR-1:0]                 addr_o,
  output logic [`BUS_DATA-1:0]                 data_o,
  output logic [3:0]                           sel_o,
  output logic                                 we_o,
  output logic                                 addr_strobe_o,
  output logic [N_SLAVES-1:0]                  c_en_s,
  input  logic [N_SLAVES-1:0][`BUS_DATA-1:0]   rd_data_s,
  input  logic [N_SLAVES-1:0]                  ready_s,
  output logic [`BUS_DATA-1:0]                 rd_data_o,
  output logic                                 ready_o,
  output logic                                 err_o
);

  localparam int IW = $clog2(N_MASTERS);
  localparam logic [SEL_W:0] SLV_LIMIT = (SEL_W+1)'(N_SLAVES);

  if (N_MASTERS < 2 || N_MASTERS > 8 || N_SLAVES < 1 || N_SLAVES > 16 ||
      (1 << SEL_W) < N_SLAVES || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bus_fabric_param: unsupported parameter set");
  end

  bus_fsm_e             state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        last_q;
  logic [SEL_W-1:0]     slv_idx_q;
  logic                 mapped_q;

  logic [N_MASTERS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 owner_valid;
  logic                 own_req;
  logic [SEL_W-1:0]     sel_live;
  logic                 mapped_live;
  logic                 ready_sel;
  logic [`BUS_DATA-1:0] rd_sel;
  logic                 timeout_hit;

  bus_rr_arbiter #(.N_MASTERS(N_MASTERS)) u_arb (
    .req        (req_m),
    .last_owner (last_q),
    .en         (state_q == IDLE),
    .gnt        (arb_gnt),
    .idx        (arb_idx)
  );

  assign owner_valid = (state_q != IDLE);
  assign grant_m     = grant_q;

  always_comb begin
    addr_o        = '0;
    data_o        = '0;
    sel_o         = '0;
    we_o          = 1'b0;
    addr_strobe_o = 1'b0;
    own_req       = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner_valid && owner_q == IW'(i)) begin
        addr_o        = addr_m[i];
        data_o        = wr_data_m[i];
        sel_o         = sel_m[i];
        we_o          = we_m[i];
        addr_strobe_o = addr_strobe_m[i];
        own_req       = req_m[i];
      end
    end
  end

  assign sel_live    = addr_o[ADDR_MSB -: SEL_W];
  assign mapped_live = ({1'b0, sel_live} < SLV_LIMIT);

  always_comb begin
    c_en_s = '0;
    for (int k = 0; k < N_SLAVES; k++)
      c_en_s[k] = owner_valid && mapped_live && (sel_live == SEL_W'(k));
  end

  // Response path follows the slave latched at the strobe, not the live address.
  always_comb begin
    ready_sel = 1'b0;
    rd_sel    = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (slv_idx_q == SEL_W'(k)) begin
        ready_sel = ready_s[k];
        rd_sel    = rd_data_s[k];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != BUSY) wait_cnt_q <= '0;
    else if (!ready_sel)        wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle without ready.
  assign timeout_hit = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    ready_o   = 1'b0;
    err_o     = 1'b0;
    rd_data_o = ERR_RDATA;
    if (state_q == BUSY) begin
      if (!mapped_q) begin
        ready_o = 1'b1;
        err_o   = 1'b1;
      end else if (ready_sel) begin
        ready_o   = 1'b1;
        rd_data_o = rd_sel;
      end else if (timeout_hit) begin
        ready_o = 1'b1;
        err_o   = 1'b1;
      end else begin
        rd_data_o = rd_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= IW'(N_MASTERS - 1);
      slv_idx_q <= '0;
      mapped_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_m) begin
            grant_q <= arb_gnt;
            owner_q <= arb_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (addr_strobe_o) begin
            slv_idx_q <= sel_live;
            mapped_q  <= mapped_live;
            state_q   <= BUSY;
          end else if (!own_req) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (ready_o) begin
            last_q  <= owner_q;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_fabric_param.sv
// Scoreboard bench for bus_fabric_param: directed cases then randomized traffic.
module tb_bus_fabric_param;

  localparam int NM = 3;
  localparam int NS = 5;
`ifdef BUS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic                  clk;
  logic                  rst;
  logic [NM-1:0]         req_m;
  logic [NM-1:0][31:0]   addr_m;
  logic [NM-1:0][31:0]   wr_data_m;
  logic [NM-1:0]         we_m;
  logic [NM-1:0][3:0]    sel_m;
  logic [NM-1:0]         addr_strobe_m;
  logic [NM-1:0]         grant_m;
  logic [31:0]           addr_o;
  logic [31:0]           data_o;
  logic [3:0]            sel_o;
  logic                  we_o;
  logic                  addr_strobe_o;
  logic [NS-1:0]         c_en_s;
  logic [NS-1:0][31:0]   rd_data_s;
  logic [NS-1:0]         ready_s;
  logic [31:0]           rd_data_o;
  logic                  ready_o;
  logic                  err_o;

  bus_fabric_param #(
    .N_MASTERS(NM), .N_SLAVES(NS), .SEL_W(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_m(req_m), .addr_m(addr_m), .wr_data_m(wr_data_m),
    .we_m(we_m), .sel_m(sel_m), .addr_strobe_m(addr_strobe_m), .grant_m(grant_m),
    .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
    .addr_strobe_o(addr_strobe_o), .c_en_s(c_en_s), .rd_data_s(rd_data_s),
    .ready_s(ready_s), .rd_data_o(rd_data_o), .ready_o(ready_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] rd;
    logic        err;
  } resp_t;

  resp_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [NM-1:0] pending = '0;
  int            last_owner = NM - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester after the last completed owner, wrapping.
  function automatic int rr_pick(input logic [NM-1:0] p, input int last);
    int c;
    for (int i = 1; i <= NM; i++) begin
      c = (last + i) % NM;
      if (p[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr(input bit mapped);
    logic [31:0] a;
    a = $urandom;
    a[31:28] = mapped ? 4'($urandom_range(0, NS - 1)) : 4'($urandom_range(NS, 15));
    return a;
  endfunction

  // Called at the negedge of an IDLE cycle with req_m == pending != 0.
  task automatic do_txn(input logic [31:0] a, input int d, input logic [31:0] data,
                        input bit chg, input logic [31:0] a2, input bit never,
                        input bit abort, input bit bg);
    int            w, s, s2;
    bit            mp, done;
    logic [NS-1:0] ce;
    logic [31:0]   wd;
    resp_t         e;
    w  = rr_pick(pending, last_owner);
    s  = int'(a[31:28]);
    s2 = int'(a2[31:28]);
    mp = (s < NS);
    ce = mp ? (NS'(1) << s) : '0;
    @(negedge clk);
    chk("grant", 64'(grant_m), 64'(1) << w);
    wd = $urandom;
    addr_m[w]        = a;
    wr_data_m[w]     = wd;
    we_m[w]          = 1'($urandom);
    sel_m[w]         = 4'($urandom);
    addr_strobe_m[w] = 1'b1;
    #1;
    chk("strobe_o", 64'(addr_strobe_o), 64'(1));
    chk("addr_o", 64'(addr_o), 64'(a));
    chk("data_o", 64'(data_o), 64'(wd));
    chk("c_en_s", 64'(c_en_s), 64'(ce));
    if (!abort) begin
      e.m   = w;
      e.rd  = (mp && !never) ? data : 32'h0;
      e.err = !mp || never;
      exp_q.push_back(e);
    end
    @(negedge clk);
    addr_strobe_m[w] = 1'b0;
    if (chg) addr_m[w] = a2;
    for (int j = 1; j <= 300; j++) begin
      ready_s = NS'($urandom);
      for (int k = 0; k < NS; k++) rd_data_s[k] = $urandom;
      if (chg && s2 < NS && s2 != s) ready_s[s2] = 1'b1;
      if (abort && j == 2) begin
        rst = 1'b1;
        if (mp) ready_s[s] = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        ready_s = '1;
        #1;
        chk("rst_grant", 64'(grant_m), 64'(0));
        chk("rst_ready", 64'(ready_o), 64'(0));
        chk("rst_c_en", 64'(c_en_s), 64'(0));
        last_owner = NM - 1;
        return;
      end
      done = !mp || (!never && j == d) || (never && j == TO);
      if (mp) begin
        ready_s[s]   = !never && (j == d);
        rd_data_s[s] = data;
      end
      if (bg && $urandom_range(0, 2) == 0) pending[$urandom_range(0, NM - 1)] = 1'b1;
      if (done) begin
        pending[w] = 1'b0;
        last_owner = w;
      end
      req_m = pending;
      if (done) break;
      @(negedge clk);
    end
    @(negedge clk);
    ready_s = NS'($urandom);
    #1;
    chk("bubble_grant", 64'(grant_m), 64'(0));
    chk("stray_ready", 64'(ready_o), 64'(0));
  endtask

  // Monitor: every response the DUT presents must match the oldest expected entry.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ready_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 64'(ready_o), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("resp_owner", 64'(grant_m), 64'(1) << e.m);
          chk("resp_rdata", 64'(rd_data_o), 64'(e.rd));
          chk("resp_err", 64'(err_o), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_m = '0; addr_m = '0; wr_data_m = '0; we_m = '0; sel_m = '0; addr_strobe_m = '0;
    rd_data_s = '0; ready_s = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_grant", 64'(grant_m), 64'(0));
    chk("reset_ready", 64'(ready_o), 64'(0));
    chk("reset_err", 64'(err_o), 64'(0));
    chk("reset_c_en", 64'(c_en_s), 64'(0));
    chk("reset_addr_o", 64'(addr_o), 64'(0));

    // Mapped read by m1, slave 3 answers two cycles after the strobe.
    pending = 3'b010; req_m = pending;
    do_txn(32'h3000_0010, 2, 32'hA5A5_0003, 0, 32'h0, 0, 0, 0);
    // Unmapped address.
    pending = 3'b001; req_m = pending;
    do_txn(32'hF000_0000, 1, 32'h0, 0, 32'h0, 0, 0, 0);
    // Address moves to slave 1 after the strobe; slave 3 still answers.
    pending = 3'b100; req_m = pending;
    do_txn(32'h3000_0040, 2, 32'h1234_5678, 1, 32'h1000_0000, 0, 0, 0);
`ifdef BUS_TIMEOUT_EN
    pending = 3'b011; req_m = pending;
    do_txn(32'h2000_0000, 1, 32'hDEAD_BEEF, 0, 32'h0, 1, 0, 0);
    do_txn(32'h4000_0000, 1, 32'h0BAD_CAFE, 0, 32'h0, 0, 0, 0);
`endif
    // All masters requesting: grants rotate.
    for (int n = 0; n < 6; n++) begin
      pending = '1; req_m = pending;
      do_txn(rand_addr(1), 1, $urandom, 0, 32'h0, 0, 0, 0);
    end
    // Reset pulse in BUSY, then m0 must win first.
    pending = '1; req_m = pending;
    do_txn(32'h2000_0000, 6, $urandom, 0, 32'h0, 0, 1, 0);
    pending = '1; req_m = pending;
    do_txn(32'h0000_0100, 1, $urandom, 0, 32'h0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      for (int m = 0; m < NM; m++)
        if (!pending[m] && $urandom_range(0, 1) == 1) pending[m] = 1'b1;
      if (pending == '0) pending[$urandom_range(0, NM - 1)] = 1'b1;
      req_m = pending;
      do_txn(rand_addr($urandom_range(0, 3) != 0), $urandom_range(1, 4), $urandom,
             $urandom_range(0, 4) == 0, $urandom, 0, 0, 1);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_fabric_param.md
# bus_fabric_param

Parametrised shared-bus fabric: N masters, M slaves, round-robin arbitration with transaction-level grant hold, top-bit address decode, and registered slave-response routing. It sits between the CPU instruction/data ports (and any later DMA or monitor master) and the memory-mapped slaves. It is the successor to the fixed two-master/five-slave bus top. It adds an unmapped-address error response and an optional response timeout.

## Interface
- `N_MASTERS`, default 2: number of masters, 2..8.
- `N_SLAVES`, default 5: number of decoded slaves, 1..16.
- `SEL_W`, default 4: address bits used for slave select, `addr[31 -: SEL_W]`. Must satisfy `2**SEL_W >= N_SLAVES`.
- `TIMEOUT_CYCLES`, default 255: maximum wait for slave ready. Only used with `BUS_TIMEOUT_EN`.
- `clk`, in, 1: the only clock. Everything is posedge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_m`, in, `[N_MASTERS]`: bus request, one bit per master.
- `addr_m`, in, `[N_MASTERS][`BUS_ADDR]`: master address.
- `wr_data_m`, in, `[N_MASTERS][`BUS_DATA]`: master write data.
- `we_m`, in, `[N_MASTERS]`: write enable.
- `sel_m`, in, `[N_MASTERS][3:0]`: byte selects.
- `addr_strobe_m`, in, `[N_MASTERS]`: one-cycle transaction start.
- `grant_m`, out, `[N_MASTERS]`: one-hot or zero grant. Registered.
- `addr_o`, `data_o`, `sel_o`, `we_o`, `addr_strobe_o`, out: owner's signals, muxed. All zero when there is no owner.
- `c_en_s`, out, `[N_SLAVES]`: one-hot slave chip enable, decoded from `addr_o` while an owner exists.
- `rd_data_s`, in, `[N_SLAVES][`BUS_DATA]`: slave read data.
- `ready_s`, in, `[N_SLAVES]`: slave ready.
- `rd_data_o`, out, `BUS_DATA`: read data returned to the owner.
- `ready_o`, out, 1: response ready to the owner.
- `err_o`, out, 1: error response, valid together with `ready_o`.

## Operation
- **FSM states:** IDLE, GRANT, BUSY.
- **IDLE:**
  - If any `req_m` bit is set, pick the winner round-robin. Search starts at `last_owner+1` and wraps at `N_MASTERS-1` to 0.
  - Register `grant_m`, then go to GRANT.
  - `last_owner` resets to `N_MASTERS-1`, so master 0 wins first.
- **GRANT:**
  - If the owner's `addr_strobe_m` is high, latch `slv_idx = addr[31 -: SEL_W]` and `mapped = (slv_idx < N_SLAVES)`, then go to BUSY.
  - If the owner drops `req_m`, clear the grant and go to IDLE.
- **BUSY:**
  - Response routing uses the latched `slv_idx`, not the live address.
  - Mapped: `ready_o = ready_s[slv_idx]` and `rd_data_o = rd_data_s[slv_idx]`.
  - Unmapped: `ready_o = 1` and `err_o = 1` on the first BUSY cycle, with `rd_data_o = 0`.
  - When `ready_o` is high, update `last_owner`, clear the grant and go to IDLE.
- **Decode:**
  - `c_en_s[k] = owner_valid && mapped_live && (addr_o[31 -: SEL_W] == k)`.
  - All `c_en_s` bits are 0 for an unmapped address.
- **Outside BUSY:** `ready_o = 0`, `err_o = 0`, `rd_data_o = 0`. Stray slave ready is ignored.
- **Requests during BUSY:** requests from non-owners are held pending. They are never dropped and never preempt the owner.
- **Reset:** at any point, including mid-transaction, `rst` returns the FSM to IDLE and clears `grant_m` to 0.

## Timing
- Request to grant: `req_m` sampled high in IDLE gives `grant_m` high on the next edge (1 cycle).
- Strobe:
  - The owner asserts `addr_strobe_m` no earlier than the first cycle in which `grant_m` is high.
  - `addr_strobe_o` is combinational from the owner's strobe, in the same cycle.
- Ready:
  - `ready_o` is combinational from the selected `ready_s` while in BUSY.
  - Minimum access is strobe, then ready one cycle later.
- Release and regrant:
  - `grant_m` falls on the edge after the `ready_o` cycle.
  - The next grant is one IDLE cycle later, so there is a 1-cycle bubble between owners.
- Simultaneous requests in IDLE: the round-robin winner is granted and the others wait. There is no starvation: any requester waits at most `N_MASTERS-1` transactions.

## Configuration
- **With `BUS_TIMEOUT_EN` defined:**
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits clears on entry to BUSY and increments each BUSY cycle without slave ready.
  - When the count reaches `TIMEOUT_CYCLES`, the fabric forces `ready_o = 1`, `err_o = 1` and `rd_data_o = 0` for one cycle, then goes to IDLE.
- **Without it:** BUSY waits indefinitely, and `err_o` is asserted only for unmapped addresses.

## Structure
- **Shared package `bus_fabric_pkg`:**
  - the FSM state enum `bus_fsm_e` (IDLE/GRANT/BUSY);
  - `localparam` decode helpers;
  - `ERR_RDATA = 32'h0`.
- **Width macros:** `BUS_ADDR` and `BUS_DATA` continue to come from `bus.h`.
- **Sub-module `bus_rr_arbiter`:** parametrised by `N_MASTERS`. Takes `req`, `last_owner` and `en`; returns a one-hot `gnt` and the binary winner index.

## Test plan
- **Round-robin grant order:** `N_MASTERS=2`, `N_SLAVES=5`, `req_m=2'b11` held, each slave answers after 1 cycle.
  - Grants alternate m0, m1, m0, m1.
  - Exactly 1 IDLE cycle between grants.
- **Mapped read:** m1 reads `addr=32'h3000_0010`, and `ready_s[3]` rises 2 cycles after the strobe with data `32'hA5A5_0003`.
  - `c_en_s=5'b01000`.
  - `rd_data_o=32'hA5A5_0003` with `ready_o=1` and `err_o=0`.
- **Unmapped address:** `addr=32'hF000_0000` with `N_SLAVES=5`.
  - `c_en_s=0`.
  - `ready_o=1` and `err_o=1` on the first BUSY cycle, `rd_data_o=0`.
  - The grant is released.
- **Address changed after strobe:** the address changes to `32'h1000_0000` after the strobe to slave 3.
  - The response is still taken from `ready_s[3]` and `rd_data_s[3]`.
  - `ready_s[1]` is ignored.
- **Timeout (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`):** the slave never asserts ready.
  - `ready_o=1` and `err_o=1` exactly 8 BUSY cycles after the strobe.
  - The next requester is granted afterwards.
- **Reset mid-transaction:** `rst` is pulsed for 1 cycle while in BUSY.
  - Next cycle: `grant_m=0`, `ready_o=0`, all `c_en_s=0`.
  - m0 wins the first grant after reset.
